// File: rtl/bcd_to_binary.sv
// bcd_to_binary: converts a four-digit BCD operand plus sign into a binary
// magnitude with reverse double-dabble. Each CONV iteration shifts
// {bcd, bin} right by one bit and then corrects any BCD nibble >= 8 by
// subtracting 3. Results are registered on the edge that leaves FIN, and
// done pulses for one cycle when they change.
module bcd_to_binary #(
  parameter int BIN_W    = 14,
  parameter int N_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       thous,
  input  logic [3:0]       hunds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  input  logic             neg,
  output logic [BIN_W-1:0] number,
  output logic             f,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CW    = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             eflag_q, eflag_d;
  logic [BIN_W-1:0] number_q;
  logic             f_q, busy_q, done_q, err_q;

  logic [BCD_W+BIN_W-1:0] cat_sh;
  logic [BCD_W-1:0]       bcd_sh;
  logic [BIN_W-1:0]       bin_sh;
  logic                   bad_digit;

  assign bad_digit = (thous > 4'd9) || (hunds > 4'd9) ||
                     (tens  > 4'd9) || (ones  > 4'd9);

  // One reverse double-dabble step: shift right, then per-nibble correction.
  always_comb begin
    cat_sh = {bcd_q, bin_q} >> 1;
    bcd_sh = cat_sh[BCD_W+BIN_W-1:BIN_W];
    bin_sh = cat_sh[BIN_W-1:0];
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_sh[4*i+3]) bcd_sh[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
    end
  end

  // Next-state logic for the control FSM and the working registers.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    eflag_d = eflag_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = BCD_W'({thous, hunds, tens, ones});
          bin_d   = '0;
          cnt_d   = '0;
          sign_d  = neg;
          eflag_d = bad_digit;
          state_d = bad_digit ? FIN : CONV;
        end
      end
      CONV: begin
        bcd_d = bcd_sh;
        bin_d = bin_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BIN_W - 1)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working registers; async reset also aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      eflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      eflag_q <= eflag_d;
    end
  end

  // Result registers: updated only on the edge leaving FIN; busy tracks CONV/FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      number_q <= '0;
      f_q      <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_q == FIN);
      if (state_q == FIN) begin
        err_q    <= eflag_q;
        number_q <= eflag_q ? '0 : bin_q;
        // Negative zero is reported as positive.
        f_q      <= ~eflag_q & sign_q & (bin_q != '0);
      end
    end
  end

  assign number = number_q;
  assign f      = f_q;
  assign err    = err_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Bench for bcd_to_binary: directed operands, scoreboard queue of expected
// results, and a monitor that pops and compares on every done pulse.
module tb_bcd_to_binary;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  thous, hunds, tens, ones;
  logic        neg;
  logic [13:0] number;
  logic        f, busy, done, err;

  typedef struct {
    logic [13:0] num;
    logic        f;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  bcd_to_binary #(.BIN_W(14), .N_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .thous(thous), .hunds(hunds), .tens(tens), .ones(ones), .neg(neg),
    .number(number), .f(f), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("number", int'(number), int'(e.num));
        chk("f", int'(f), int'(e.f));
        chk("err", int'(err), int'(e.err));
      end
    end
  end

  task automatic push(input int n, input logic ef, input logic ee);
    exp_t e;
    e.num = 14'(n); e.f = ef; e.err = ee;
    exp_q.push_back(e);
  endtask

  // Issue one conversion, check start-to-done latency (edges) and busy width.
  task automatic run(input logic [3:0] a, b, c, d, input logic sg,
                     input int expn, input logic ef, input logic ee,
                     input int lat, input int busy_exp, input bit poke);
    int k;
    int bcnt;
    bit seen;
    @(negedge clk);
    thous = a; hunds = b; tens = c; ones = d; neg = sg; start = 1'b1;
    push(expn, ef, ee);
    @(posedge clk); #1;
    start = 1'b0;
    // Inputs changed after the start edge must not matter.
    thous = 4'd3; hunds = 4'd3; tens = 4'd3; ones = 4'd3; neg = ~sg;
    bcnt = busy ? 1 : 0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (done) seen = 1'b1;
      else if (busy) bcnt++;
      if (poke && k == 5) begin
        thous = 4'd1; hunds = 4'd1; tens = 4'd1; ones = 4'd1; start = 1'b1;
      end
      if (poke && k == 6) start = 1'b0;
    end
    chk("done_seen", int'(seen), 1);
    chk("latency", k, lat);
    if (busy_exp >= 0) chk("busy_cycles", bcnt, busy_exp);
    @(negedge clk);
  endtask

  initial begin
    int last, k, cyc;
    rst = 1'b1; start = 1'b0; neg = 1'b0;
    thous = '0; hunds = '0; tens = '0; ones = '0;
    #12;
    chk("rst_number", int'(number), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_f", int'(f), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    run(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 9999, 1'b0, 1'b0, 15, 15, 1'b0);
    run(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1234, 1'b1, 1'b0, 15, -1, 1'b0);
    run(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 0,    1'b0, 1'b0, 15, -1, 1'b0);
    run(4'd0, 4'd5, 4'd0, 4'd8, 1'b0, 508,  1'b0, 1'b0, 15, -1, 1'b1);
    // No late second done from the ignored start.
    repeat (20) @(negedge clk);
    run(4'd1, 4'hA, 4'd0, 4'd0, 1'b1, 0,    1'b0, 1'b1, 1,  -1, 1'b0);
    run(4'd0, 4'd0, 4'd4, 4'd2, 1'b0, 42,   1'b0, 1'b0, 15, -1, 1'b0);
    run(4'd0, 4'd0, 4'd0, 4'd9, 1'b1, 9,    1'b1, 1'b0, 15, -1, 1'b0);

    // Abort mid-conversion with async reset.
    @(negedge clk);
    thous = 4'd1; hunds = 4'd2; tens = 4'd3; ones = 4'd4; neg = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_number", int'(number), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk); rst = 1'b0;
    repeat (25) @(negedge clk);
    run(4'd7, 4'd0, 4'd0, 4'd0, 1'b0, 7000, 1'b0, 1'b0, 15, -1, 1'b0);

    // Back-to-back with start held high: done every 16 edges.
    @(negedge clk);
    thous = 4'd0; hunds = 4'd0; tens = 4'd1; ones = 4'd5; neg = 1'b0; start = 1'b1;
    repeat (3) push(15, 1'b0, 1'b0);
    last = 0;
    cyc = 0;
    for (int n = 0; n < 3; n++) begin
      k = 0;
      while (k < 40) begin
        @(posedge clk); #1;
        cyc++; k++;
        if (done) break;
      end
      if (n == 2) start = 1'b0;
      chk("b2b_done_seen", int'(done), 1);
      if (n > 0) chk("b2b_interval", cyc - last, 16);
      last = cyc;
    end
    repeat (30) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
